max10nios_pio_capture_in: RTL and testbench

//  Parametrised Avalon-MM input PIO for the NIOS system; successor to the fixed 8-bit level-only input port.

---
 rtl/max10nios_pio_capture_in_pkg.sv | 17 +
 rtl/max10nios_pio_capture_in_if.sv | 21 ++
 rtl/max10nios_pio_capture_in_bit_sync.sv | 33 +++
 rtl/max10nios_pio_capture_in.sv | 96 +++++++++
 tb/tb_max10nios_pio_capture_in.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/max10nios_pio_capture_in_pkg.sv
// rtl/max10nios_pio_capture_in_pkg.sv - register map and mode encodings for the capture-input PIO
package max10nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_NONE  = 0;
    localparam int IRQ_LEVEL = 1;
    localparam int IRQ_EDGE  = 2;

endpackage

// File: rtl/max10nios_pio_capture_in_if.sv
// rtl/max10nios_pio_capture_in_if.sv - Avalon-MM slave bus (s1) plus interrupt line
interface max10nios_pio_capture_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/max10nios_pio_capture_in_bit_sync.sv
// rtl/max10nios_pio_capture_in_bit_sync.sv - multi-bit metastability synchroniser, STAGES=0 passes through
module max10nios_bit_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [WIDTH-1:0] chain [STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain <= '{default: '0};
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/max10nios_pio_capture_in.sv
// rtl/max10nios_pio_capture_in.sv - input PIO with per-bit edge capture, W1C clear and maskable irq
module max10nios_pio_capture_in
    import max10nios_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int IRQ_TYPE    = IRQ_EDGE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     in_port,
    max10nios_pio_capture_in_if.slave s1
);

    logic [DATA_WIDTH-1:0]  s;
    logic [DATA_WIDTH-1:0]  prev;
    logic [DATA_WIDTH-1:0]  irqmask;
    logic [DATA_WIDTH-1:0]  edgecap;
    logic [DATA_WIDTH-1:0]  edge_det;
    logic [DATA_WIDTH-1:0]  w1c;
    logic [SYNC_STAGES:0]   prime_sr;
    logic                   primed;
    logic                   wr_en;
    logic [31:0]            rd_mux;

    max10nios_bit_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (s)
    );

    // Arm only once the sync chain and prev both hold post-reset samples, so an
    // input held high through reset never looks like a fresh edge.
    assign primed = prime_sr[SYNC_STAGES];
    assign wr_en  = s1.chipselect & ~s1.write_n;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_det = s & ~prev;
            EDGE_FALLING: edge_det = ~s & prev;
            default:      edge_det = s ^ prev;
        endcase
        if (!primed) begin
            edge_det = '0;
        end
    end

    always_comb begin
        w1c = '0;
        if (wr_en && s1.address == ADDR_EDGECAP) begin
            w1c = s1.writedata[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s1.address)
            ADDR_DATA:    rd_mux = 32'(s);
            ADDR_IRQMASK: rd_mux = 32'(irqmask);
            ADDR_EDGECAP: rd_mux = 32'(edgecap);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            prime_sr    <= '0;
            irqmask     <= '0;
            edgecap     <= '0;
            s1.readdata <= '0;
            s1.irq      <= 1'b0;
        end else begin
            prev        <= s;
            prime_sr    <= (prime_sr << 1) | (SYNC_STAGES + 1)'(1);
            s1.readdata <= rd_mux;
            if (wr_en && s1.address == ADDR_IRQMASK) begin
                irqmask <= s1.writedata[DATA_WIDTH-1:0];
            end
            // A new edge overrides a same-cycle clear of that bit.
            edgecap <= (edgecap & ~w1c) | edge_det;
            case (IRQ_TYPE)
                IRQ_LEVEL: s1.irq <= |(s & irqmask);
                IRQ_EDGE:  s1.irq <= |(edgecap & irqmask);
                default:   s1.irq <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_max10nios_pio_capture_in.sv
// tb/tb_max10nios_pio_capture_in.sv - directed bench for 8-bit rising and 32-bit any-edge PIO instances
module tb_max10nios_pio_capture_in;
    import max10nios_pio_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in8;
    logic [31:0] in32;
    int          tests;
    int          fails;

    max10nios_pio_capture_in_if bus8 ();
    max10nios_pio_capture_in_if bus32 ();

    max10nios_pio_capture_in #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (EDGE_RISING),
        .IRQ_TYPE    (IRQ_EDGE)
    ) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in8),
        .s1      (bus8)
    );

    max10nios_pio_capture_in #(
        .DATA_WIDTH  (32),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (EDGE_ANY),
        .IRQ_TYPE    (IRQ_EDGE)
    ) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in32),
        .s1      (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr8(input logic [1:0] a, input logic [31:0] d);
        bus8.address    = a;
        bus8.writedata  = d;
        bus8.chipselect = 1'b1;
        bus8.write_n    = 1'b0;
        tick(1);
        bus8.chipselect = 1'b0;
        bus8.write_n    = 1'b1;
    endtask

    task automatic rd8(input logic [1:0] a, input string tag, input logic [31:0] exp);
        bus8.address    = a;
        bus8.chipselect = 1'b1;
        bus8.write_n    = 1'b1;
        tick(1);
        check(tag, bus8.readdata, exp);
        bus8.chipselect = 1'b0;
    endtask

    task automatic wr32(input logic [1:0] a, input logic [31:0] d);
        bus32.address    = a;
        bus32.writedata  = d;
        bus32.chipselect = 1'b1;
        bus32.write_n    = 1'b0;
        tick(1);
        bus32.chipselect = 1'b0;
        bus32.write_n    = 1'b1;
    endtask

    task automatic rd32(input logic [1:0] a, input string tag, input logic [31:0] exp);
        bus32.address    = a;
        bus32.chipselect = 1'b1;
        bus32.write_n    = 1'b1;
        tick(1);
        check(tag, bus32.readdata, exp);
        bus32.chipselect = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n          = 1'b0;
        in8              = 8'hFF;
        in32             = 32'h0;
        bus8.address     = ADDR_DATA;
        bus8.chipselect  = 1'b0;
        bus8.write_n     = 1'b1;
        bus8.writedata   = 32'h0;
        bus32.address    = ADDR_DATA;
        bus32.chipselect = 1'b0;
        bus32.write_n    = 1'b1;
        bus32.writedata  = 32'h0;

        // Reset with inputs high, then release and idle
        tick(3);
        check("rst_readdata8", bus8.readdata, 32'h0);
        check("rst_irq8", {31'h0, bus8.irq}, 32'h0);
        reset_n = 1'b1;
        tick(10);
        rd8(ADDR_EDGECAP, "t1_edgecap_no_spurious", 32'h0);
        check("t1_irq", {31'h0, bus8.irq}, 32'h0);
        rd8(ADDR_DATA, "t1_data_level", 32'h0000_00FF);

        // Rising-edge capture; falling edges ignored
        in8 = 8'h00;
        tick(5);
        rd8(ADDR_EDGECAP, "t2_falling_ignored", 32'h0);
        in8 = 8'h05;
        tick(3);
        rd8(ADDR_EDGECAP, "t2_capture_05", 32'h05);
        wr8(ADDR_EDGECAP, 32'h01);
        rd8(ADDR_EDGECAP, "t2_w1c_bit0", 32'h04);

        // Edge irq latency and W1C deassertion
        wr8(ADDR_EDGECAP, 32'hFF);
        in8 = 8'h00;
        tick(4);
        wr8(ADDR_IRQMASK, 32'hFFFF_FF04);
        rd8(ADDR_IRQMASK, "t3_irqmask", 32'h04);
        check("t3_irq_idle", {31'h0, bus8.irq}, 32'h0);
        in8 = 8'h04;
        tick(3);
        check("t3_irq_before_4cyc", {31'h0, bus8.irq}, 32'h0);
        tick(1);
        check("t3_irq_at_4cyc", {31'h0, bus8.irq}, 32'h1);
        wr8(ADDR_EDGECAP, 32'h04);
        check("t3_irq_same_cycle_as_w1c", {31'h0, bus8.irq}, 32'h1);
        tick(1);
        check("t3_irq_cleared", {31'h0, bus8.irq}, 32'h0);

        // Edge set collides with W1C on bit 1: set wins
        in8 = 8'h06;
        tick(2);
        wr8(ADDR_EDGECAP, 32'h02);
        rd8(ADDR_EDGECAP, "t4_set_beats_w1c", 32'h02);
        wr8(ADDR_EDGECAP, 32'hFF);
        rd8(ADDR_EDGECAP, "t4_cleared", 32'h0);

        // Writes to DATA and reserved words have no effect
        wr8(ADDR_DATA, 32'h0000_0000);
        wr8(ADDR_RSVD, 32'hFFFF_FFFF);
        rd8(ADDR_DATA, "t6_data_unchanged", 32'h06);
        rd8(ADDR_RSVD, "t6_rsvd_zero", 32'h0);
        rd8(ADDR_IRQMASK, "t6_mask_unchanged", 32'h04);
        rd8(ADDR_EDGECAP, "t6_edgecap_unchanged", 32'h0);

        // 32-bit any-edge capture
        in32 = 32'h8000_0001;
        tick(3);
        rd32(ADDR_EDGECAP, "t5_rise_capture", 32'h8000_0001);
        wr32(ADDR_EDGECAP, 32'hFFFF_FFFF);
        rd32(ADDR_EDGECAP, "t5_clear1", 32'h0);
        in32 = 32'h0;
        tick(3);
        rd32(ADDR_EDGECAP, "t5_fall_capture", 32'h8000_0001);
        wr32(ADDR_EDGECAP, 32'hFFFF_FFFF);
        rd32(ADDR_EDGECAP, "t5_clear2", 32'h0);
        rd32(ADDR_DATA, "t5_data", 32'h0);
        check("t5_irq_masked", {31'h0, bus32.irq}, 32'h0);

        // Reset asserted mid-burst clears everything asynchronously
        in8 = 8'h00;
        tick(4);
        in8  = 8'h0F;
        in32 = 32'hFFFF_FFFF;
        tick(4);
        bus8.address  = ADDR_EDGECAP;
        bus32.address = ADDR_EDGECAP;
        tick(1);
        check("t6_pre_edgecap8", bus8.readdata, 32'h0F);
        check("t6_pre_irq8", {31'h0, bus8.irq}, 32'h1);
        check("t6_pre_edgecap32", bus32.readdata, 32'hFFFF_FFFF);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_readdata8", bus8.readdata, 32'h0);
        check("t6_rst_irq8", {31'h0, bus8.irq}, 32'h0);
        check("t6_rst_readdata32", bus32.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(10);
        rd8(ADDR_EDGECAP, "t6_post_edgecap8", 32'h0);
        rd32(ADDR_EDGECAP, "t6_post_edgecap32", 32'h0);
        rd8(ADDR_IRQMASK, "t6_post_mask", 32'h0);
        check("t6_post_irq8", {31'h0, bus8.irq}, 32'h0);
        in8 = 8'h1F;
        tick(3);
        rd8(ADDR_EDGECAP, "t6_rearmed_edge", 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
